// File: rtl/ksa_ft_pkg.sv
// Shared types and helpers for the fault-tolerant Kogge-Stone sequencer.
package ksa_ft_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    CMP  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Core width: one guard bit for the shifted pass plus one for its carry.
  function automatic int core_width(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/ksa_core.sv
// Combinational Kogge-Stone prefix adder with a generate-vector flip hook.
module ksa_core
  import ksa_ft_pkg::*;
#(
  parameter int N = 18
)(
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  input  logic [N-1:0] i_g_flip,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  localparam int L = clog2(N);

  logic [N-1:0]      w_p0;
  logic [N-1:0]      w_gen;
  logic [L:0][N-1:0] w_g;
  logic [L:0][N-1:0] w_p;

  assign w_p0  = i_a ^ i_b;
  // The flip lands on the raw generate vector so one bit models one faulty cell.
  assign w_gen = (i_a & i_b) ^ i_g_flip;
  // Carry-in folded into bit 0 so every G[i] becomes the carry out of bit i.
  assign w_g[0] = {w_gen[N-1:1], w_gen[0] | (w_p0[0] & i_cin)};
  assign w_p[0] = w_p0;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int D = 1 << k;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign w_g[k+1][i] = w_g[k][i];
        assign w_p[k+1][i] = w_p[k][i];
      end else if (i < 2 * D) begin : g_gray
        // Lower span already reaches bit 0, so only the group generate matters.
        assign w_g[k+1][i] = w_g[k][i] | (w_p[k][i] & w_g[k][i-D]);
        assign w_p[k+1][i] = w_p[k][i];
      end else begin : g_black
        assign w_g[k+1][i] = w_g[k][i] | (w_p[k][i] & w_g[k][i-D]);
        assign w_p[k+1][i] = w_p[k][i] & w_p[k][i-D];
      end
    end
  end

  assign o_sum  = w_p0 ^ {w_g[L][N-2:0], i_cin};
  assign o_cout = w_g[L][N-1];

endmodule

// File: rtl/ksa_ft_seq.sv
// Time-redundant adder: normal pass, shifted pass, compare, bounded retry.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// P1    | normal pass through the core, result into r_res1
// P2    | shifted-by-one pass through the core, result into r_res2
// CMP   | compare passes; retry or publish result
// OUT   | result presented, held until out_ready
module ksa_ft_seq
  import ksa_ft_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter int  RETRY_MAX = 2,
  localparam int RW        = (clog2(RETRY_MAX + 1) < 1) ? 1 : clog2(RETRY_MAX + 1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic [RW-1:0]    retries,
  input  logic             fault_en,
  input  logic             fault_perm,
  input  logic [WIDTH+1:0] fault_mask
);

  localparam int            N    = core_width(WIDTH);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [N-1:0]     r_res1;
  logic [N-1:0]     r_res2;
  logic [RW-1:0]    r_retry;

  logic [N-1:0]     w_core_a;
  logic [N-1:0]     w_core_b;
  logic             w_core_cin;
  logic [N-1:0]     w_flip;
  logic [N-1:0]     w_core_sum;
  logic             w_core_cout;
  logic             w_inject;
  logic             w_match;

  // Operand steering: the shifted pass moves cin into bit 0 of both operands.
  always_comb begin
    w_core_a   = {2'b00, r_a};
    w_core_b   = {2'b00, r_b};
    w_core_cin = r_cin;
    if (r_state == P2) begin
      w_core_a   = {1'b0, r_a, r_cin};
      w_core_b   = {1'b0, r_b, r_cin};
      w_core_cin = 1'b0;
    end
  end

  // Same physical mask in both passes lands one logical bit apart, forcing a disagreement.
  always_comb begin
    w_inject = 1'b0;
    if (fault_en) begin
      if (fault_perm) w_inject = (r_state == P1) || (r_state == P2);
      else            w_inject = (r_state == P1) && (r_retry == '0);
    end
    w_flip = w_inject ? fault_mask : '0;
  end

  assign w_match = (r_res1[WIDTH:0] == r_res2[WIDTH+1:1]);

  ksa_core #(.N(N)) u_core (
    .i_a      (w_core_a),
    .i_b      (w_core_b),
    .i_cin    (w_core_cin),
    .i_g_flip (w_flip),
    .o_sum    (w_core_sum),
    .o_cout   (w_core_cout)
  );

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_res1    <= '0;
      r_res2    <= '0;
      r_retry   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      retries   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_cin    <= cin;
            r_retry  <= '0;
            in_ready <= 1'b0;
            r_state  <= P1;
          end
        end
        P1: begin
          r_res1  <= w_core_sum;
          r_state <= P2;
        end
        P2: begin
          r_res2  <= w_core_sum;
          r_state <= CMP;
        end
        CMP: begin
          if (!w_match && (r_retry < RMAX)) begin
            r_retry <= r_retry + RW'(1);
            r_state <= P1;
          end else begin
            // Unresolved mismatch still publishes the normal-pass result.
            sum       <= r_res1[WIDTH-1:0];
            cout      <= r_res1[WIDTH];
            err       <= !w_match;
            retries   <= r_retry;
            out_valid <= 1'b1;
            r_state   <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
